// File: rtl/lfp_requant_e4m4_to_e3m4.sv
// lfp_requant_e4m4_to_e3m4
// Two-stage valid/ready requantizer on the LSTM return path. It takes E4M4
// multiplier products ({s, e[3:0], m[3:0]}) and returns E3M4 storage values
// ({s, e[2:0], m[3:0]}). The doubled bias is removed by subtracting BIAS_SUB.
// Overflow saturates to the largest magnitude and underflow flushes to zero.
// Both events are flagged on the output and counted on delivery.
module lfp_requant_e4m4_to_e3m4 #(
    parameter int BIAS_SUB = 3,   // legal range 0..15
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic             out_uf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_cnt,
    output logic [CNT_W-1:0] uf_cnt
);

    // Outcome of converting one E4M4 value.
    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_UF,
        CLS_SAT
    } conv_cls_t;

    localparam logic [4:0] BIAS5 = 5'(BIAS_SUB);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    // Both stages move together. The pipeline advances whenever the output
    // register is empty or is being consumed. Bubbles are not collapsed.
    logic adv;
    logic out_hs;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign out_hs   = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Stage 1: capture the raw E4M4 sample
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic [8:0] s1_data;

    // Stage-1 valid: cleared by reset, so in-flight samples are dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. This keeps
        // every register reading pre-edge values regardless of block ordering.
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 payload: advances with the pipeline and is never reset.
    always_ff @(posedge clk) begin
        // NOTE: the payload register has no reset on purpose. It is meaningless
        // while s1_valid=0, and leaving out the reset saves a mux on every bit.
        if (adv) begin
            s1_data <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Conversion (combinational, from stage-1 contents)
    // ------------------------------------------------------------------
    logic              s1_s;
    logic [3:0]        s1_e;
    logic [3:0]        s1_m;
    logic signed [4:0] d;
    conv_cls_t         cls;
    logic [7:0]        conv_data;
    logic              conv_sat;
    logic              conv_uf;

    assign s1_s = s1_data[8];
    assign s1_e = s1_data[7:4];
    assign s1_m = s1_data[3:0];

    // Debias the exponent. The operands are 0..15, so 5 signed bits hold the
    // full -15..15 range of d.
    assign d = signed'({1'b0, s1_e}) - signed'(BIAS5);

    // Classify the sample into zero, normal, underflow or saturation.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        cls = CLS_NORM;
        if (s1_e == 4'd0) begin
            cls = CLS_ZERO;
        end else if (d < 5'sd1) begin
            cls = CLS_UF;
        end else if (d > 5'sd7) begin
            cls = CLS_SAT;
        end
    end

    // Form the E3M4 word and its event flags from the class.
    always_comb begin
        conv_data = 8'h00;
        conv_sat  = 1'b0;
        conv_uf   = 1'b0;
        unique case (cls)
            CLS_ZERO: begin
                conv_data = 8'h00;
            end
            CLS_NORM: begin
                conv_data = {s1_s, d[2:0], s1_m};
            end
            CLS_UF: begin
                // Flush to +0. The sign is deliberately dropped.
                conv_data = 8'h00;
                conv_uf   = 1'b1;
            end
            CLS_SAT: begin
                // Largest finite magnitude, keeping the sign.
                conv_data = {s1_s, 7'h7F};
                conv_sat  = 1'b1;
            end
            default: begin
                conv_data = 8'h00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: registered result, held stable while stalled
    // ------------------------------------------------------------------
    // Output register: loads the converted sample on advance, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sat   <= 1'b0;
            out_uf    <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_data  <= conv_data;
            out_sat   <= conv_sat;
            out_uf    <= conv_uf;
        end
    end

    // ------------------------------------------------------------------
    // Event counters: count delivered results, saturate, clear has priority
    // ------------------------------------------------------------------
    // Saturation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clr_cnt) begin
            sat_cnt <= '0;
        end else if (out_hs && out_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    // Underflow counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_cnt <= '0;
        end else if (clr_cnt) begin
            uf_cnt <= '0;
        end else if (out_hs && out_uf && (uf_cnt != '1)) begin
            uf_cnt <= uf_cnt + 1'b1;
        end
    end

endmodule
